// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   DEFAULT_WIDTH - default operand width used by seq_multiplier
//   mul_state_t   - control states IDLE / RUN / DONE
//   cnt_width()   - width of the iteration counter for a given operand width
package seq_multiplier_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

    // One extra bit over clog2 so the counter can represent WIDTH itself
    // without wrapping, even for power-of-two widths.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/seq_multiplier_adder_n.sv
// Ripple-carry adder used as the single arithmetic element of the multiplier.
// Latency: purely combinational, carry ripples through n full-adder cells.
// Backpressure: none, output always reflects the current inputs.
//
// Ports:
//   X, Y     - n-bit addends
//   CarryIn  - carry into bit 0
//   Sum      - n-bit sum
//   CarryOut - carry out of bit n-1
module adder_n #(
    parameter int n = 32
) (
    input  logic [n-1:0] X,
    input  logic [n-1:0] Y,
    input  logic         CarryIn,
    output logic [n-1:0] Sum,
    output logic         CarryOut
);

    logic [n:0] carry;

    assign carry[0] = CarryIn;

    for (genvar i = 0; i < n; i++) begin : g_fa
        logic prop;
        assign prop         = X[i] ^ Y[i];
        assign Sum[i]       = prop ^ carry[i];
        assign carry[i + 1] = (X[i] & Y[i]) | (carry[i] & prop);
    end

    assign CarryOut = carry[n];

endmodule

// File: rtl/seq_multiplier.sv
// Unsigned WIDTH x WIDTH sequential multiplier, one shift-and-add step per clock.
// Latency: accepting edge + WIDTH RUN edges; Done pulses in the following cycle.
// Backpressure: Start is ignored while Busy; a Start in the DONE cycle is accepted.
//
// Ports:
//   Clk          - clock, all state on the rising edge
//   Reset        - synchronous active-high reset, overrides Start
//   Start        - request a multiply (accepted in IDLE or DONE)
//   Multiplicand - operand A, captured on the accepting edge
//   Multiplier   - operand B, captured on the accepting edge
//   Busy         - high during the WIDTH iteration cycles
//   Done         - one-cycle pulse when Product is valid
//   Product      - 2*WIDTH-bit result, held from Done until the next accepted Start
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [WIDTH-1:0]     Multiplicand,
    input  logic [WIDTH-1:0]     Multiplier,
    output logic                 Busy,
    output logic                 Done,
    output logic [2*WIDTH-1:0]   Product
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    mul_state_t          state,     state_nxt;
    logic [CW-1:0]       cnt,       cnt_nxt;
    logic [WIDTH-1:0]    mcand,     mcand_nxt;
    // acc[2W-1:W] is the running partial sum; acc[W-1:0] starts as the
    // multiplier and is consumed one bit per cycle from the bottom while
    // product bits shift in from the top.
    logic [2*WIDTH-1:0]  acc,       acc_nxt;

    logic [WIDTH-1:0]    add_y;
    logic [WIDTH-1:0]    add_sum;
    logic                add_cout;

    assign add_y = acc[0] ? mcand : '0;

    adder_n #(
        .n        (WIDTH)
    ) u_adder (
        .X        (acc[2*WIDTH-1:WIDTH]),
        .Y        (add_y),
        .CarryIn  (1'b0),
        .Sum      (add_sum),
        .CarryOut (add_cout)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mcand_nxt = mcand;
        acc_nxt   = acc;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    mcand_nxt = Multiplicand;
                    cnt_nxt   = '0;
                    acc_nxt   = {{WIDTH{1'b0}}, Multiplier};
                    state_nxt = ST_RUN;
                end else if (state == ST_DONE) begin
                    state_nxt = ST_IDLE;
                end
            end

            ST_RUN: begin
                // Carry-out becomes the new MSB so a full-width sum never
                // loses its top bit during the right shift.
                acc_nxt = {add_cout, add_sum, acc[WIDTH-1:1]};
                cnt_nxt = cnt + CW'(1);
                if (cnt == LAST_CNT) begin
                    state_nxt = ST_DONE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            mcand <= '0;
            acc   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            mcand <= mcand_nxt;
            acc   <= acc_nxt;
        end
    end

    assign Busy    = (state == ST_RUN);
    assign Done    = (state == ST_DONE);
    assign Product = acc;

endmodule
